// File: rtl/psg_sched_pkg.sv
// Shared types and constants for the YM2149 PSG write scheduler.
package psg_sched_pkg;

  localparam int PSG_AW = 4;
  localparam int PSG_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [PSG_AW-1:0] addr;
    logic [PSG_DW-1:0] data;
  } wr_entry_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/psg_write_sched_if.sv
// Request handshakes of both write requesters plus the PSG write bus.
interface psg_write_sched_if;
  import psg_sched_pkg::*;

  logic              req0_valid;
  logic [PSG_AW-1:0] req0_addr;
  logic [PSG_DW-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [PSG_AW-1:0] req1_addr;
  logic [PSG_DW-1:0] req1_data;
  logic              req1_ready;
  logic [PSG_AW-1:0] psg_addr;
  logic [PSG_DW-1:0] psg_din;
  logic              psg_cs_n;
  logic              psg_wr_n;

  // Requester side: issues writes and observes the PSG bus.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  psg_addr, psg_din, psg_cs_n, psg_wr_n
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output psg_addr, psg_din, psg_cs_n, psg_wr_n
  );

endinterface

// File: rtl/psg_sched_fifo.sv
// Synchronous FIFO of pending PSG register writes; push/pop may coincide.
module psg_sched_fifo
  import psg_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wr_entry_t              wdata,
  input  logic                   pop,
  output wr_entry_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t         mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/psg_write_sched.sv
// Two-port round-robin write scheduler driving the YM2149 PSG bus in clk_en ticks.
// Optional feature macro: PSG_SCHED_SHADOW_EN (16x8 shadow of written registers).
module psg_write_sched
  import psg_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int WR_HOLD = 2,
  parameter int WR_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  psg_write_sched_if.slave       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
`ifdef PSG_SCHED_SHADOW_EN
  ,
  input  logic [PSG_AW-1:0]      shadow_addr,
  output logic [PSG_DW-1:0]      shadow_data
`endif
);

  localparam int CW = $clog2(max2(WR_HOLD, WR_GAP) + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(WR_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(WR_GAP - 1);

  logic        full;
  logic        empty;
  logic        push0;
  logic        push1;
  logic        push;
  logic        pop;
  logic        last_gnt;
  wr_entry_t   wdata;
  wr_entry_t   head;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              cs_n_q;
  logic              wr_n_q;
  logic [PSG_AW-1:0] addr_q;
  logic [PSG_DW-1:0] din_q;
  logic              gap_done;

  // last_gnt = 1 means port 1 won the most recent push, so port 0 is favoured next.
  assign bus.req0_ready = bus.req0_valid & ~full & (~bus.req1_valid | last_gnt);
  assign bus.req1_ready = bus.req1_valid & ~full & (~bus.req0_valid | ~last_gnt);

  assign push0 = bus.req0_valid & bus.req0_ready;
  assign push1 = bus.req1_valid & bus.req1_ready;
  assign push  = push0 | push1;
  assign wdata = push0 ? wr_entry_t'{addr: bus.req0_addr, data: bus.req0_data}
                       : wr_entry_t'{addr: bus.req1_addr, data: bus.req1_data};

  always_ff @(posedge clk) begin
    if (!rst_n)     last_gnt <= 1'b1;
    else if (push0) last_gnt <= 1'b0;
    else if (push1) last_gnt <= 1'b1;
  end

  psg_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The FIFO head is consumed on the same tick that it is latched onto the bus.
  assign gap_done = (state == GAP) && (cnt == '0);
  assign pop      = clk_en & ~empty & ((state == IDLE) | gap_done);
  assign busy     = ~empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state  <= SETUP;
            cs_n_q <= 1'b0;
            addr_q <= head.addr;
            din_q  <= head.data;
            cnt    <= '0;
          end
        end
        SETUP: begin
          state  <= STROBE;
          wr_n_q <= 1'b0;
          cnt    <= HOLD_LD;
        end
        STROBE: begin
          if (cnt == '0) begin
            state  <= GAP;
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            cnt    <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!empty) begin
            state  <= SETUP;
            cs_n_q <= 1'b0;
            addr_q <= head.addr;
            din_q  <= head.data;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.psg_addr = addr_q;
  assign bus.psg_din  = din_q;
  assign bus.psg_cs_n = cs_n_q;
  assign bus.psg_wr_n = wr_n_q;

`ifdef PSG_SCHED_SHADOW_EN
  logic [PSG_DW-1:0] shadow [16];

  // Captured on the SETUP->STROBE tick, i.e. as the write strobe begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (clk_en && (state == SETUP)) begin
      shadow[addr_q] <= din_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) shadow_data <= '0;
    else        shadow_data <= shadow[shadow_addr];
  end
`endif

endmodule

// File: tb/tb_psg_write_sched.sv
// Randomised and directed bench for psg_write_sched against a queue-based write model.
module tb_psg_write_sched;
  import psg_sched_pkg::*;

  localparam int DEPTH  = 8;
  localparam int H      = 2;
  localparam int G      = 2;
  localparam int PERIOD = 1 + H + G;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [3:0] level;
  logic       busy;
`ifdef PSG_SCHED_SHADOW_EN
  logic [3:0] shadow_addr = '0;
  logic [7:0] shadow_data;
`endif

  psg_write_sched_if bus ();

  psg_write_sched #(.DEPTH(DEPTH), .WR_HOLD(H), .WR_GAP(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .bus         (bus),
    .level       (level),
    .busy        (busy)
`ifdef PSG_SCHED_SHADOW_EN
    ,
    .shadow_addr (shadow_addr),
    .shadow_data (shadow_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending writes, bus occupancy in ticks, last grant.
  wr_entry_t mq[$];
  wr_entry_t m_cur;
  int        m_left;
  bit        m_active;
  bit        m_last;
  int        nedges;
  logic      prev_wr_n;

  task automatic model_reset();
    mq.delete();
    m_cur    = '0;
    m_left   = 0;
    m_active = 1'b0;
    m_last   = 1'b1;
  endtask

  task automatic check_bus();
    logic exp_cs_n, exp_wr_n;
    exp_cs_n = !(m_left >= G);
    exp_wr_n = !(m_left >= G && m_left <= G + H - 1);
    chk("level",  32'(level), 32'(mq.size()));
    chk("cs_n",   32'(bus.psg_cs_n), 32'(exp_cs_n));
    chk("wr_n",   32'(bus.psg_wr_n), 32'(exp_wr_n));
    chk("addr",   32'(bus.psg_addr), 32'(m_cur.addr));
    chk("din",    32'(bus.psg_din),  32'(m_cur.data));
    chk("busy",   32'(busy), 32'((mq.size() != 0) || m_active));
  endtask

  task automatic cycle(input bit v0, input logic [3:0] a0, input logic [7:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [7:0] d1,
                       input bit ce);
    bit er0, er1;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    clk_en = ce;
    #1;
    er0 = v0 && (mq.size() < DEPTH) && (!v1 || m_last);
    er1 = v1 && (mq.size() < DEPTH) && (!v0 || !m_last);
    chk("ready0", 32'(bus.req0_ready), 32'(er0));
    chk("ready1", 32'(bus.req1_ready), 32'(er1));
    @(posedge clk);
    #1;
    if (ce) begin
      if (m_left == 0 && mq.size() != 0) begin
        m_cur    = mq.pop_front();
        m_left   = PERIOD - 1;
        m_active = 1'b1;
      end else if (m_left != 0) begin
        m_left--;
      end else begin
        m_active = 1'b0;
      end
    end
    if (er0) begin
      mq.push_back('{addr: a0, data: d0});
      m_last = 1'b0;
    end else if (er1) begin
      mq.push_back('{addr: a1, data: d1});
      m_last = 1'b1;
    end
    check_bus();
    if (prev_wr_n === 1'b1 && bus.psg_wr_n === 1'b0) nedges++;
    prev_wr_n = bus.psg_wr_n;
  endtask

  task automatic idle(input int n, input bit ce);
    for (int i = 0; i < n; i++) cycle(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, ce);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_cs_n",  32'(bus.psg_cs_n), 32'd1);
    chk("rst_wr_n",  32'(bus.psg_wr_n), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_addr",  32'(bus.psg_addr), 32'd0);
    chk("rst_din",   32'(bus.psg_din), 32'd0);
    prev_wr_n = bus.psg_wr_n;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    bit hit;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    nedges = 0;
    prev_wr_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    apply_reset();

    // Single envelope-shape write with sparse clk_en.
    e0 = nedges;
    for (int i = 0; i < 32; i++)
      cycle(i == 0, 4'hD, 8'h0E, 0, 4'h0, 8'h00, (i % 4) == 3);
    chk("single_edges", 32'(nedges - e0), 32'd1);

    // Repeated reg 0xD writes must each produce their own strobe.
    e0 = nedges;
    cycle(1, 4'hD, 8'h0A, 0, 4'h0, 8'h00, 1'b1);
    cycle(1, 4'hD, 8'h0A, 0, 4'h0, 8'h00, 1'b1);
    idle(16, 1'b1);
    chk("repeat_edges", 32'(nedges - e0), 32'd2);

    // Both ports continuously valid: grants alternate starting with port 0.
    apply_reset();
    for (int i = 0; i < 6; i++)
      cycle(1, 4'h1, 8'(8'h10 + i), 1, 4'h2, 8'(8'h20 + i), 1'b0);
    chk("rr_level", 32'(level), 32'd6);
    idle(40, 1'b1);

    // Fill to full with the PSG clock stopped.
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1, 4'(i), 8'($urandom), 0, 4'h0, 8'h00, 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH));
    cycle(1, 4'h7, 8'h77, 0, 4'h0, 8'h00, 1'b1);
    chk("pop_level", 32'(level), 32'(DEPTH - 1));
    cycle(1, 4'h7, 8'h78, 0, 4'h0, 8'h00, 1'b0);
    idle(70, 1'b1);

    // Reset in the middle of a strobe aborts it and drops queued writes.
    cycle(1, 4'h3, 8'h33, 0, 4'h0, 8'h00, 1'b1);
    cycle(1, 4'h4, 8'h44, 0, 4'h0, 8'h00, 1'b1);
    cycle(1, 4'h5, 8'h55, 0, 4'h0, 8'h00, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.psg_wr_n === 1'b0) hit = 1'b1;
      else idle(1, 1'b1);
    end
    chk("strobe_reached", 32'(hit), 32'd1);
    apply_reset();
    e0 = nedges;
    idle(20, 1'b1);
    chk("post_rst_edges", 32'(nedges - e0), 32'd0);

`ifdef PSG_SCHED_SHADOW_EN
    cycle(1, 4'h8, 8'h1F, 0, 4'h0, 8'h00, 1'b1);
    idle(10, 1'b1);
    @(negedge clk); shadow_addr = 4'h8;
    @(posedge clk); #1;
    chk("shadow8", 32'(shadow_data), 32'h1F);
    @(negedge clk); shadow_addr = 4'h3;
    @(posedge clk); #1;
    chk("shadow3", 32'(shadow_data), 32'h00);
`endif

    // Random traffic with varying clk_en density.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 2) != 0, 4'($urandom), 8'($urandom),
            $urandom_range(0, 2) == 0, 4'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0);
    idle(120, 1'b1);
    chk("drained_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
